// File: rtl/top_level_decrypt_if.sv
// Run handshake between the controller (test harness) and the decrypter.
// req is the controller's go/hold request, ack is the decrypter's completion flag.
interface top_level_decrypt_if;
    logic req;
    logic ack;

    modport master (output req, input ack);
    modport slave  (input req, output ack);
endinterface

// File: rtl/top_level_decrypt.sv
// LFSR message decrypter: recovers tap and seed from space padding, then writes the
// decrypted, de-padded and parity-flagged message to the low 64 bytes of its memory.

module top_level_decrypt_dmem (
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] waddr,
    input  logic [7:0] wdata,
    input  logic [7:0] raddr,
    output logic [7:0] rdata
);
    logic [7:0] core [0:255];

    assign rdata = core[raddr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the array is deliberately not reset, so contents preloaded during reset survive it.
    always_ff @(posedge clk) begin
        if (we) core[waddr] <= wdata;
    end
endmodule

module top_level_decrypt (
    input logic                 clk,
    input logic                 init,
    top_level_decrypt_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_SEED, S_SEARCH, S_DECRYPT, S_FILL, S_DONE
    } state_t;

    state_t     state, state_nxt;
    logic [5:0] idx;        // cipher byte index, memory address is 64 + idx
    logic [5:0] seed_idx;
    logic [6:0] seed;
    logic [6:0] lfsr;
    logic [3:0] tap_sel;
    logic [6:0] wr_ptr;     // bit 6 set means the low half is fully written
    logic       started;

    logic       mem_we;
    logic [7:0] mem_waddr, mem_wdata, mem_raddr, mem_rdata;

    logic [6:0] cur_tap, predicted, cipher, plain;
    logic       perr, last_pad, search_miss, keep_byte;

    function automatic logic [6:0] tap_of(input logic [3:0] k);
        case (k)
            4'd0:    tap_of = 7'h60;
            4'd1:    tap_of = 7'h48;
            4'd2:    tap_of = 7'h78;
            4'd3:    tap_of = 7'h72;
            4'd4:    tap_of = 7'h6A;
            4'd5:    tap_of = 7'h69;
            4'd6:    tap_of = 7'h5C;
            4'd7:    tap_of = 7'h7E;
            4'd8:    tap_of = 7'h7B;
            default: tap_of = 7'h60;
        endcase
    endfunction

    top_level_decrypt_dmem DM (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    assign cur_tap   = tap_of(tap_sel);
    assign predicted = {lfsr[5:0], ^(lfsr & cur_tap)};
    assign cipher    = mem_rdata[6:0];
    assign perr      = ^mem_rdata;
    assign plain     = cipher ^ lfsr;
    assign last_pad  = (idx == 6'd9);
    // Bad-parity padding bytes carry no reliable LFSR state, so they never veto a tap.
    assign search_miss = !perr && (predicted != cipher);
    assign keep_byte   = (idx >= 6'd10) && (started || (plain != 7'd0) || perr);

    always_ff @(posedge clk or negedge init) begin
        if (!init) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        // NOTE: default first so every path assigns the output and no latch is inferred.
        state_nxt = state;
        case (state)
            S_IDLE:    if (!bus.req) state_nxt = S_SEED;
            S_SEED: begin
                if (last_pad)  state_nxt = S_DECRYPT;
                else if (!perr) state_nxt = S_SEARCH;
            end
            S_SEARCH: begin
                if ((search_miss && tap_sel == 4'd8) || (!search_miss && last_pad))
                    state_nxt = S_DECRYPT;
            end
            S_DECRYPT: if (idx == 6'd63) state_nxt = S_FILL;
            S_FILL:    if (wr_ptr >= 7'd63) state_nxt = S_DONE;
            S_DONE:    if (bus.req) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.ack   = (state == S_DONE);
        mem_raddr = {2'b01, idx};
        mem_we    = 1'b0;
        mem_waddr = {1'b0, wr_ptr};
        mem_wdata = 8'h00;
        case (state)
            S_DECRYPT: begin
                mem_we    = keep_byte;
                mem_wdata = {perr, plain};
            end
            S_FILL:  mem_we = !wr_ptr[6];
            default: mem_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge init) begin
        if (!init) begin
            idx      <= '0;
            seed_idx <= '0;
            seed     <= '0;
            lfsr     <= '0;
            tap_sel  <= '0;
            wr_ptr   <= '0;
            started  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    idx      <= '0;
                    seed_idx <= '0;
                    seed     <= '0;
                    lfsr     <= '0;
                    tap_sel  <= '0;
                    wr_ptr   <= '0;
                    started  <= 1'b0;
                end
                S_SEED: begin
                    // With no good-parity pad before index 9, index 9 seeds and no tap can be vetoed.
                    if (last_pad || !perr) begin
                        seed_idx <= idx;
                        seed     <= cipher;
                        lfsr     <= cipher;
                        idx      <= last_pad ? idx : idx + 6'd1;
                    end else begin
                        idx <= idx + 6'd1;
                    end
                end
                S_SEARCH: begin
                    if (search_miss) begin
                        lfsr <= seed;
                        if (tap_sel == 4'd8) begin
                            tap_sel <= '0;
                            idx     <= seed_idx;
                        end else begin
                            tap_sel <= tap_sel + 4'd1;
                            idx     <= seed_idx + 6'd1;
                        end
                    end else if (last_pad) begin
                        lfsr <= seed;
                        idx  <= seed_idx;
                    end else begin
                        lfsr <= predicted;
                        idx  <= idx + 6'd1;
                    end
                end
                S_DECRYPT: begin
                    // Decryption restarts at the seed index; indices below 10 are never written.
                    lfsr <= predicted;
                    idx  <= idx + 6'd1;
                    if (keep_byte) begin
                        started <= 1'b1;
                        wr_ptr  <= wr_ptr + 7'd1;
                    end
                end
                S_FILL: begin
                    if (!wr_ptr[6]) wr_ptr <= wr_ptr + 7'd1;
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_top_level_decrypt.sv
// Randomised scoreboard bench for top_level_decrypt: expected memory images come from a
// spec-level reference model and are compared by a monitor whenever ack rises.
module tb_top_level_decrypt;
    typedef logic [7:0] mem_t [0:255];
    typedef logic [6:0] pt_t  [0:63];

    logic clk  = 1'b0;
    logic init = 1'b0;
    logic mon_prev = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] exp_q [$];
    mem_t img;

    top_level_decrypt_if bus ();

    top_level_decrypt dut (
        .clk  (clk),
        .init (init),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] tap_of(input int k);
        logic [6:0] t [0:8];
        t = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};
        return t[k];
    endfunction

    function automatic logic [6:0] step(input logic [6:0] s, input logic [6:0] t);
        return {s[5:0], ^(s & t)};
    endfunction

    // Encrypt plaintext into a fresh image; the rest of memory is random junk.
    task automatic build(input pt_t pt, input int k, input logic [6:0] seed0);
        logic [6:0] s;
        logic [6:0] c;
        s = seed0;
        for (int a = 0; a < 256; a++) img[a] = 8'($urandom);
        for (int i = 0; i < 64; i++) begin
            c = pt[i] ^ s;
            img[64 + i] = {^c, c};
            s = step(s, tap_of(k));
        end
    endtask

    task automatic flip(input int i, input int b);
        img[64 + i][b] = ~img[64 + i][b];
    endtask

    // Reference: seed search, tap selection, decryption and de-padding over plain arrays.
    function automatic void model(input mem_t m, output mem_t e);
        logic [7:0] c [0:63];
        logic [6:0] l [0:63];
        bit         good [0:63];
        logic [6:0] s;
        int         j, sel, st;
        bit         ok;
        for (int i = 0; i < 64; i++) begin
            c[i]    = m[64 + i];
            good[i] = ((^c[i]) == 1'b0);
            l[i]    = '0;
        end
        j = 9;
        for (int i = 9; i >= 0; i--) if (good[i]) j = i;
        sel = -1;
        for (int k = 0; k < 9; k++) begin
            if (sel < 0) begin
                s  = c[j][6:0];
                ok = 1'b1;
                for (int i = j + 1; i <= 9; i++) begin
                    s = step(s, tap_of(k));
                    if (good[i] && s != c[i][6:0]) ok = 1'b0;
                end
                if (ok) sel = k;
            end
        end
        if (sel < 0) sel = 0;
        l[j] = c[j][6:0];
        for (int i = j; i < 63; i++) l[i + 1] = step(l[i], tap_of(sel));
        st = 10;
        while (st < 64 && (c[st][6:0] ^ l[st]) == 7'd0 && good[st]) st++;
        e = m;
        for (int n = 0; n < 64; n++)
            e[n] = (st + n < 64) ? {!good[st + n], c[st + n][6:0] ^ l[st + n]} : 8'h00;
    endfunction

    // Monitor: compare the whole memory against the queued image on every ack rise.
    initial begin
        logic [7:0] ev;
        forever begin
            @(negedge clk);
            if (bus.ack === 1'b1 && !mon_prev) begin
                if (exp_q.size() < 256) begin
                    check("sb_underflow", exp_q.size(), 256);
                end else begin
                    for (int a = 0; a < 256; a++) begin
                        ev = exp_q.pop_front();
                        check($sformatf("core[%0d]", a), dut.DM.core[a], ev);
                    end
                end
            end
            mon_prev = bus.ack;
        end
    end

    task automatic load_and_reset();
        init    = 1'b0;
        bus.req = 1'b1;
        @(negedge clk);
        for (int a = 0; a < 256; a++) dut.DM.core[a] = img[a];
        check("reset_ack", bus.ack, 0);
        @(negedge clk);
        init = 1'b1;
    endtask

    task automatic run(input int hold, input bit pulse, input bit abort_done);
        mem_t e;
        int   cyc, diff;
        bit   seen;
        model(img, e);
        load_and_reset();
        if (hold > 0) begin
            diff = 0;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (bus.ack !== 1'b0) diff++;
            end
            check("hold_ack_high_cycles", diff, 0);
            diff = 0;
            for (int a = 0; a < 64; a++) if (dut.DM.core[a] !== img[a]) diff++;
            check("hold_mem_changed", diff, 0);
        end
        for (int a = 0; a < 256; a++) exp_q.push_back(e[a]);
        bus.req = 1'b0;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (pulse && cyc == 20) bus.req = 1'b1;
            if (pulse && cyc == 23) bus.req = 1'b0;
            if (bus.ack === 1'b1) seen = 1'b1;
        end
        check("ack_seen", seen, 1);
        check("latency_le_250", (seen && cyc <= 250), 1);
        if (!seen) exp_q.delete();
        @(negedge clk);
        if (seen) check("ack_held", bus.ack, 1);
        if (abort_done) begin
            #1 init = 1'b0;
            #1 check("init_in_done_ack", bus.ack, 0);
        end else begin
            bus.req = 1'b1;
            @(negedge clk);
            check("ack_drop_on_req", bus.ack, 0);
        end
    endtask

    task automatic set_msg(output pt_t pt, input int pre, input string msg);
        logic [7:0] ch;
        for (int i = 0; i < 64; i++) pt[i] = 7'd0;
        for (int i = 0; i < msg.len() && pre + i < 64; i++) begin
            ch = msg[i];
            pt[pre + i] = 7'(ch - 8'h20);
        end
    endtask

    task automatic rand_msg(output pt_t pt, input int pre);
        for (int i = 0; i < 64; i++)
            pt[i] = (i < pre) ? 7'd0 : 7'($urandom_range(0, 8'h5E));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        pt_t        pt;
        logic [6:0] seed;
        int         diff, pre, k, fb;
        string      watson;
        watson  = "Mr. Watson, come here. I want to see you.";
        bus.req = 1'b1;

        // All-space plaintext, also exercising req held high after reset.
        for (int i = 0; i < 64; i++) pt[i] = 7'd0;
        build(pt, 0, 7'h01);
        run(100, 1'b0, 1'b0);

        seed = 7'($urandom_range(1, 127));
        set_msg(pt, 12, watson);
        build(pt, 0, seed);
        run(0, 1'b0, 1'b0);
        check("watson_first", dut.DM.core[0], 8'h2D);
        check("watson_tail", dut.DM.core[63], 8'h00);

        build(pt, 0, seed);
        fb = $urandom_range(0, 6);
        flip(30, fb);
        run(0, 1'b0, 1'b0);
        check("watson_flip_bit7", dut.DM.core[18][7], 1);

        set_msg(pt, 10, "  0123456789ABCDEFGHIJKLMNOPQRSTUVWXYZ");
        build(pt, 8, 7'($urandom_range(1, 127)));
        run(0, 1'b0, 1'b0);
        check("spaces_stripped", dut.DM.core[0], 8'h10);

        for (int t = 0; t < 9; t++) begin
            rand_msg(pt, 10);
            build(pt, t, 7'h7F);
            run(0, 1'b0, 1'b0);
        end

        // Abort mid-run: ack drops at once and the cipher half is left alone.
        rand_msg(pt, 10);
        build(pt, 3, 7'h55);
        load_and_reset();
        @(negedge clk);
        bus.req = 1'b0;
        repeat (40) @(negedge clk);
        #1 init = 1'b0;
        #1 check("abort_mid_ack", bus.ack, 0);
        diff = 0;
        for (int a = 64; a < 256; a++) if (dut.DM.core[a] !== img[a]) diff++;
        check("abort_upper_untouched", diff, 0);

        for (int r = 0; r < 8; r++) begin
            pre  = $urandom_range(10, 20);
            k    = $urandom_range(0, 8);
            seed = 7'($urandom_range(1, 127));
            rand_msg(pt, pre);
            build(pt, k, seed);
            if (r % 2 == 1) flip($urandom_range(0, 9), $urandom_range(0, 6));
            for (int f = 0; f < r % 4; f++) flip($urandom_range(10, 63), $urandom_range(0, 6));
            run(0, (r == 3), (r == 7));
        end

        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/top_level_decrypt.md
# top_level_decrypt

Hardwired message decrypter and de-padder for the program 3 flow. It reads a 64-byte LFSR-encrypted, parity-tagged message from its internal data memory and recovers the 7-bit LFSR tap pattern and starting state from the known space pre-padding. It then writes the decrypted message, with leading spaces stripped and parity errors flagged, back to the low half of the same memory. The testbench preloads and inspects the memory by hierarchical access and controls the block only through `req`/`ack`.

## Interface
- No parameters. Tap table fixed: 0x60, 0x48, 0x78, 0x72, 0x6A, 0x69, 0x5C, 0x7E, 0x7B (index 0..8).
- `clk` input 1: single clock, rising edge.
- `init` input 1: reset, asynchronous, active-low.
- `req` input 1: high holds the engine idle; low after reset starts or continues a run.
- `ack` output 1: run complete.
- Internal memory instance `DM` with array `core[0:255]` of 8 bits is hierarchically visible for backdoor load and check.

## Operation
- Input: ciphertext byte i (0..63) at `core[64+i]`. Bit 7 is even parity over bits 6:0. Bits 6:0 = plaintext[i] XOR lfsr[i].
- Plaintext is ASCII minus 0x20, so a space is 0x00. Bytes 0..9 are always padding with plaintext 0x00.
- LFSR step: next = {s[5:0], ^(s & tap)}.
- A byte has a parity error when ^core[64+i][7:0] == 1.
- SEARCH:
  - Seed index j = first of 0..9 with good parity; seed = cipher[j][6:0].
  - For tap k = 0..8: step the seed forward and compare the predicted state with cipher[i][6:0] for every good-parity i in j+1..9.
  - The first k with all compares matching is selected. If none match, use k = 0.
- DECRYPT: regenerate lfsr[0..63] by stepping back to index 0, or equivalently by seeding at j and stepping the selected tap. Compute p[i] = cipher[i][6:0] ^ lfsr[i] and out[i] = {perr[i], p[i]}.
- DEPAD:
  - Skip indices 0..9 unconditionally.
  - Then skip further indices while p[i] == 0 and perr[i] == 0.
  - The first non-skipped index s maps to `core[0]`; index s+n is written to `core[n]`.
- FILL: `core[64-s .. 63]` are written with 0x00.
- `core[128..255]` and `core[64..127]` are never written.

## Timing
- Reset (`init` low, async): state IDLE, `ack` = 0, all counters and registers 0. Memory contents are not cleared, so a preload made during reset survives.
- IDLE: remain while `req` = 1. When `req` = 0, go to SEARCH on the next edge.
- Memory read is combinational, with at most one write per cycle. Reads and writes are disjoint in address, so there is no hazard.
- SEARCH: at most 9 taps × 10 cycles.
- DECRYPT/DEPAD: 1 byte per cycle, 64 cycles.
- FILL: 1 byte per cycle.
- Total run: at most 250 cycles from the `req` fall to `ack` rise.
- DONE: `ack` = 1 and held until `init` asserts or `req` returns high. `req` high in DONE returns to IDLE with `ack` = 0.
- `req` rising mid-run is ignored; the run completes. `init` mid-run aborts immediately, leaving memory partially written.

## Test plan
- All-0x00 plaintext, tap 0x60, seed 0x01, no flips → `core[0..63]` all 0x00, `ack` within 250 cycles.
- "Mr. Watson, come here. I want to see you." with pre_length 12, tap 0x60, random nonzero seed → `core[0]` = 0x2D ('M'−0x20), bytes follow in order, tail 0x00.
- Same message but with a single bit flip in message byte 30 → that output byte has bit 7 = 1 and its other bytes are correct.
- Message "  01234…" (two leading spaces), tap 0x7B → the two leading spaces are stripped and `core[0]` = 0x10 ('0'−0x20).
- Loop over each of the 9 taps with seed 0x7F → correct decryption every time, confirming tap detection.
- Hold `req` high for 100 cycles after reset → `ack` stays 0 and memory is untouched. Assert `init` mid-run → `ack` = 0 at once.
